// File: rtl/gcd_lcm_stage.sv
// Captures (a, b, gcd) on a gcd_done rising edge and computes lcm = a*b/gcd.
// Shift-add multiply (W cycles), restoring divide (2W cycles), then one write-back edge.
module gcd_lcm_stage #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   gcd,
    input  logic           gcd_done,
    output logic [2*W-1:0] lcm,
    output logic           lcm_valid,
    output logic           busy,
    output logic           div_err,
    output logic           overrun
);
    localparam int CW = $clog2(2 * W);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_WB, S_DONE} state_t;

    state_t         state_q, state_d;
    logic           done_q;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   rb_q, rb_d;
    logic [W-1:0]   rg_q, rg_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W:0]     rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] lcm_q, lcm_d;
    logic           lcm_valid_q, lcm_valid_d;
    logic           div_err_q, div_err_d;
    logic           overrun_q, overrun_d;
    logic           rise;
    logic [W:0]     rem_sh;

    assign rise   = gcd_done & ~done_q;
    // acc doubles as the product during MUL and the dividend/quotient during DIV
    assign rem_sh = {rem_q[W-1:0], acc_q[2*W-1]};

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        rb_d        = rb_q;
        rg_d        = rg_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        lcm_d       = lcm_q;
        lcm_valid_d = lcm_valid_q;
        div_err_d   = div_err_q;
        overrun_d   = overrun_q;

        case (state_q)
            S_MUL: begin
                if (rb_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                rb_d    = rb_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DIV;
                    cnt_d   = '0;
                    rem_d   = '0;
                    if (rg_q == '0) acc_d = '0;
                end
                if (rise) overrun_d = 1'b1;
            end
            S_DIV: begin
                if (rg_q != '0) begin
                    if (rem_sh >= {1'b0, rg_q}) begin
                        rem_d = rem_sh - {1'b0, rg_q};
                        acc_d = {acc_q[2*W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        acc_d = {acc_q[2*W-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(2 * W - 1)) state_d = S_WB;
                if (rise) overrun_d = 1'b1;
            end
            S_WB: begin
                lcm_d       = acc_q;
                lcm_valid_d = 1'b1;
                div_err_d   = (rg_q == '0);
                state_d     = S_DONE;
            end
            default: ;
        endcase

        // Not busy: a rise starts a fresh computation, overriding any write-back
        if (rise && state_q != S_MUL && state_q != S_DIV) begin
            mcand_d     = {{W{1'b0}}, a};
            rb_d        = b;
            rg_d        = gcd;
            acc_d       = '0;
            rem_d       = '0;
            cnt_d       = '0;
            lcm_valid_d = 1'b0;
            div_err_d   = 1'b0;
            state_d     = S_MUL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            done_q      <= 1'b0;
            mcand_q     <= '0;
            rb_q        <= '0;
            rg_q        <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            lcm_q       <= '0;
            lcm_valid_q <= 1'b0;
            div_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= gcd_done;
            mcand_q     <= mcand_d;
            rb_q        <= rb_d;
            rg_q        <= rg_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            lcm_q       <= lcm_d;
            lcm_valid_q <= lcm_valid_d;
            div_err_q   <= div_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign lcm       = lcm_q;
    assign lcm_valid = lcm_valid_q;
    assign div_err   = div_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
endmodule
